// File: rtl/riscv_enc_pkg.sv
// rtl/riscv_enc_pkg.sv - shared format/error codes and immediate limits for inst_encoder
package riscv_enc_pkg;

   typedef enum logic [2:0] {
      FMT_R       = 3'd0,
      FMT_I       = 3'd1,
      FMT_I_SHIFT = 3'd2,
      FMT_S       = 3'd3,
      FMT_B       = 3'd4,
      FMT_U       = 3'd5,
      FMT_J       = 3'd6,
      FMT_BAD     = 3'd7
   } fmt_e;

   typedef enum logic [1:0] {
      ERR_NONE  = 2'd0,
      ERR_RANGE = 2'd1,
      ERR_ALIGN = 2'd2,
      ERR_FMT   = 2'd3
   } err_e;

   localparam int IMM12_MIN = -2048;
   localparam int IMM12_MAX = 2047;
   localparam int SHAMT_MIN = 0;
   localparam int SHAMT_MAX = 31;
   localparam int B_MIN     = -4096;
   localparam int B_MAX     = 4094;
   localparam int J_MIN     = -1048576;
   localparam int J_MAX     = 1048574;

   function automatic logic in_range(input logic signed [31:0] v, input int lo, input int hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/enc_fifo.sv
// rtl/enc_fifo.sv - synchronous FIFO holding encoded words with their tagged addresses
module enc_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [WIDTH-1:0] last_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // When empty the output keeps showing the most recently popped entry.
   assign rdata = empty ? last_q : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         last_q <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            last_q <= mem[rd_ptr];
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - packs RV32I fields into instruction words, range-checks, tags and queues them
module inst_encoder
   import riscv_enc_pkg::*;
#(
   parameter int                DEPTH     = 4,
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        fmt,
   input  logic [6:0]        opcode,
   input  logic [4:0]        rd,
   input  logic [4:0]        rs1,
   input  logic [4:0]        rs2,
   input  logic [2:0]        funct3,
   input  logic [6:0]        funct7,
   input  logic [31:0]       imm,
   input  logic              addr_load,
   input  logic [ADDR_W-1:0] addr_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_inst,
   output logic [ADDR_W-1:0] out_addr,
   output logic              err,
   output logic [1:0]        err_code,
   input  logic              clr_err
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [31:0]        enc_inst;
   err_e               code;
   logic               accept;
   logic               push;
   logic [ADDR_W-1:0]  addr_q;
   logic [ADDR_W-1:0]  entry_addr;
   logic [1:0]         err_code_q;
   logic [CW-1:0]      fifo_count;
   logic               fifo_full;
   logic               fifo_empty;
   logic [31+ADDR_W:0] fifo_rdata;

   always_comb begin
      enc_inst = '0;
      code     = ERR_NONE;
      case (fmt_e'(fmt))
         FMT_R: begin
            enc_inst = {funct7, rs2, rs1, funct3, rd, opcode};
         end
         FMT_I: begin
            enc_inst = {imm[11:0], rs1, funct3, rd, opcode};
            if (!in_range(imm, IMM12_MIN, IMM12_MAX)) code = ERR_RANGE;
         end
         FMT_I_SHIFT: begin
            enc_inst = {funct7, imm[4:0], rs1, funct3, rd, opcode};
            if (!in_range(imm, SHAMT_MIN, SHAMT_MAX)) code = ERR_RANGE;
         end
         FMT_S: begin
            enc_inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            if (!in_range(imm, IMM12_MIN, IMM12_MAX)) code = ERR_RANGE;
         end
         FMT_B: begin
            enc_inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            if (imm[0])                           code = ERR_ALIGN;
            else if (!in_range(imm, B_MIN, B_MAX)) code = ERR_RANGE;
         end
         FMT_U: begin
            enc_inst = {imm[31:12], rd, opcode};
            if (imm[11:0] != 12'd0) code = ERR_ALIGN;
         end
         FMT_J: begin
            enc_inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            if (imm[0])                           code = ERR_ALIGN;
            else if (!in_range(imm, J_MIN, J_MAX)) code = ERR_RANGE;
         end
         default: begin
            code = ERR_FMT;
         end
      endcase
   end

   assign in_ready   = rst_n && (fifo_count < CW'(DEPTH));
   assign accept     = in_valid && in_ready;
   assign push       = accept && (code == ERR_NONE) && !fifo_full;
   // A load in the same cycle as an enqueue tags the entry with the loaded value.
   assign entry_addr = addr_load ? addr_in : addr_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_q <= BASE_ADDR;
      end else if (addr_load) begin
         addr_q <= push ? addr_in + ADDR_W'(4) : addr_in;
      end else if (push) begin
         addr_q <= addr_q + ADDR_W'(4);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err        <= 1'b0;
         err_code_q <= 2'd0;
      end else if (accept && (code != ERR_NONE)) begin
         err        <= 1'b1;
         err_code_q <= code;
      end else if (clr_err) begin
         err        <= 1'b0;
         err_code_q <= 2'd0;
      end
   end

   assign err_code = err_code_q;

   enc_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (32 + ADDR_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata ({enc_inst, entry_addr}),
      .pop   (out_ready),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign out_valid = !fifo_empty;
   assign out_inst  = fifo_rdata[ADDR_W +: 32];
   assign out_addr  = fifo_rdata[ADDR_W-1:0];

endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - directed self-checking bench for inst_encoder
module tb_inst_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  fmt;
   logic [6:0]  opcode;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm;
   logic        addr_load;
   logic [31:0] addr_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [31:0] out_addr;
   logic        err;
   logic [1:0]  err_code;
   logic        clr_err;

   int checks   = 0;
   int failures = 0;

   inst_encoder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .fmt       (fmt),
      .opcode    (opcode),
      .rd        (rd),
      .rs1       (rs1),
      .rs2       (rs2),
      .funct3    (funct3),
      .funct7    (funct7),
      .imm       (imm),
      .addr_load (addr_load),
      .addr_in   (addr_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_inst  (out_inst),
      .out_addr  (out_addr),
      .err       (err),
      .err_code  (err_code),
      .clr_err   (clr_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] im);
      in_valid = 1'b1;
      fmt      = f;
      opcode   = op;
      rd       = d;
      rs1      = s1;
      rs2      = s2;
      funct3   = f3;
      funct7   = f7;
      imm      = im;
   endtask

   // ADDI xN, x0, N
   task automatic addi_n(input logic [4:0] n);
      req(3'd1, 7'h13, n, 5'd0, 5'd0, 3'd0, 7'd0, {27'd0, n});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; fmt = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0;
      funct3 = '0; funct7 = '0; imm = '0; addr_load = 1'b0; addr_in = '0; out_ready = 1'b0;
      clr_err = 1'b0;
      tick(); tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_inst", out_inst, 0);
      chk("rst_out_addr", out_addr, 0);
      chk("rst_err", err, 0);
      chk("rst_err_code", err_code, 0);
      chk("rst_in_ready", in_ready, 0);
      rst_n = 1'b1;
      tick();
      chk("post_rst_in_ready", in_ready, 1);

      // Streamed legal encodings with out_ready held high
      out_ready = 1'b1;
      req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF); tick();
      chk("addi_valid", out_valid, 1);
      chk("addi_inst", out_inst, 32'hFFF00093);
      chk("addi_addr", out_addr, 32'h0);
      req(3'd2, 7'h13, 5'd5, 5'd5, 5'd0, 3'd5, 7'h20, 32'd3); tick();
      chk("srai_inst", out_inst, 32'h4032D293);
      chk("srai_addr", out_addr, 32'h4);
      req(3'd6, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8); tick();
      chk("jal_inst", out_inst, 32'h008000EF);
      chk("jal_addr", out_addr, 32'h8);
      req(3'd4, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC); tick();
      chk("beq_inst", out_inst, 32'hFE208EE3);
      chk("beq_addr", out_addr, 32'hC);
      req(3'd3, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFF_FFF8); tick();
      chk("sw_inst", out_inst, 32'hFE20AC23);
      chk("sw_addr", out_addr, 32'h10);
      req(3'd5, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000); tick();
      chk("lui_inst", out_inst, 32'h123450B7);
      chk("lui_addr", out_addr, 32'h14);
      req(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEAD_BEEF); tick();
      chk("add_inst", out_inst, 32'h002081B3);
      chk("add_addr", out_addr, 32'h18);
      req(3'd4, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4094); tick();
      chk("bmax_inst", out_inst, 32'h7E208FE3);
      chk("bmax_addr", out_addr, 32'h1C);
      chk("no_err_yet", err, 0);

      // Rejected requests
      req(3'd4, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFD); tick();
      chk("bodd_valid", out_valid, 0);
      chk("bodd_err", err, 1);
      chk("bodd_code", err_code, 2);
      chk("bodd_last_inst", out_inst, 32'h7E208FE3);
      req(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0); tick();
      chk("fmt7_code", err_code, 3);
      req(3'd2, 7'h13, 5'd1, 5'd1, 5'd0, 3'd1, 7'd0, 32'd32); tick();
      chk("shamt32_code", err_code, 1);
      req(3'd5, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001); tick();
      chk("u_low_code", err_code, 2);
      req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048); tick();
      chk("addi2048_code", err_code, 1);
      chk("errors_not_queued", out_valid, 0);
      in_valid = 1'b0;
      clr_err = 1'b1; tick();
      chk("clr_err", err, 0);
      chk("clr_code", err_code, 0);
      req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048); tick();
      chk("set_beats_clr_err", err, 1);
      chk("set_beats_clr_code", err_code, 1);
      clr_err = 1'b0;
      req(3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0); tick();
      in_valid = 1'b0;
      chk("nop_inst", out_inst, 32'h00000013);
      chk("counter_held_on_err", out_addr, 32'h20);
      tick();

      // Fill to full with consumer stalled, then drain
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      out_ready = 1'b0;
      addi_n(5'd1); tick();
      addi_n(5'd2); tick();
      addi_n(5'd3); tick();
      chk("fill3_in_ready", in_ready, 1);
      addi_n(5'd4); tick();
      chk("full_in_ready", in_ready, 0);
      chk("full_head_inst", out_inst, 32'h00100093);
      chk("full_head_addr", out_addr, 32'h0);
      addi_n(5'd5); tick();
      chk("held_in_ready", in_ready, 0);
      chk("stall_head_inst", out_inst, 32'h00100093);
      out_ready = 1'b1; tick();
      in_valid = 1'b0;
      chk("drain1_inst", out_inst, 32'h00200113);
      chk("drain1_addr", out_addr, 32'h4);
      chk("drain1_in_ready", in_ready, 1);
      tick();
      chk("drain2_inst", out_inst, 32'h00300193);
      chk("drain2_addr", out_addr, 32'h8);
      tick();
      chk("drain3_inst", out_inst, 32'h00400213);
      chk("drain3_addr", out_addr, 32'hC);
      tick();
      chk("full_push_refused", out_valid, 0);

      // Address load and wrap
      out_ready = 1'b0;
      addr_load = 1'b1; addr_in = 32'hFFFF_FFFC; tick();
      addr_load = 1'b0;
      addi_n(5'd1); tick();
      addi_n(5'd2); tick();
      in_valid = 1'b0;
      chk("load_addr", out_addr, 32'hFFFF_FFFC);
      out_ready = 1'b1; tick();
      chk("wrap_addr", out_addr, 32'h0);
      chk("wrap_inst", out_inst, 32'h00200113);
      tick();
      chk("wrap_drained", out_valid, 0);
      out_ready = 1'b0;
      addr_load = 1'b1; addr_in = 32'h100; addi_n(5'd3); tick();
      addr_load = 1'b0; addi_n(5'd4); tick();
      in_valid = 1'b0;
      chk("load_push_addr", out_addr, 32'h100);
      out_ready = 1'b1; tick();
      chk("load_push_next_addr", out_addr, 32'h104);
      tick();

      // Reset mid-burst
      out_ready = 1'b0;
      addi_n(5'd1); tick();
      addi_n(5'd2); tick();
      addi_n(5'd3); tick();
      in_valid = 1'b0;
      chk("burst_valid", out_valid, 1);
      rst_n = 1'b0; tick();
      chk("midrst_valid", out_valid, 0);
      chk("midrst_inst", out_inst, 0);
      chk("midrst_addr", out_addr, 0);
      chk("midrst_in_ready", in_ready, 0);
      rst_n = 1'b1;
      addi_n(5'd6); tick();
      in_valid = 1'b0;
      chk("after_rst_valid", out_valid, 1);
      chk("after_rst_addr", out_addr, 32'h0);
      chk("after_rst_inst", out_inst, 32'h00600313);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Inverse of the immediate generator: packs opcode, register fields, funct fields and a signed 32-bit immediate into a legal RV32I instruction word.
- Range-checks the immediate per format. Accepted words are buffered in a small FIFO, each tagged with an auto-incrementing instruction-memory address.
- Used by the boot/self-test loader to write instruction memory. Rejected requests are dropped and flagged.

Parameters:
- DEPTH, 4, output FIFO entries (power of two, ≥2)
- ADDR_W, 32, width of the address counter and out_addr
- BASE_ADDR, 32'h0, counter value after reset

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active low
- in_valid  in  1  request valid
- in_ready  out  1  request can be accepted
- fmt  in  3  format: 0=R, 1=I, 2=I_SHIFT, 3=S, 4=B, 5=U, 6=J; 7 is illegal
- opcode  in  7  inst[6:0]
- rd, rs1, rs2  in  5 each  register fields
- funct3  in  3  inst[14:12]
- funct7  in  7  inst[31:25] (R and I_SHIFT only)
- imm  in  32  full signed immediate value; for U, the final value with low 12 bits zero
- addr_load  in  1  load the address counter from addr_in
- addr_in  in  ADDR_W  counter load value
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_inst  out  32  encoded instruction
- out_addr  out  ADDR_W  address tagged at enqueue
- err  out  1  sticky range/format error
- err_code  out  2  last error: 1=range, 2=alignment, 3=bad fmt
- clr_err  in  1  clear err and err_code

Behaviour:
- Reset (rst_n low at posedge): FIFO empty; out_valid=0; out_inst=0; out_addr=0; err=0; err_code=0; counter=BASE_ADDR. in_ready=0 during reset. Reset mid-burst discards all FIFO contents.
- Handshake: a request is accepted when in_valid && in_ready. in_ready = (count < DEPTH), so there is no bypass when full, even if a pop happens the same cycle.
- Encoding is combinational on the inputs. An accepted legal request is written to the FIFO at that edge, giving out_valid=1 one cycle later (latency 1).
- Range checks, in signed 32-bit:
  - I and S: −2048..2047.
  - I_SHIFT: imm 0..31.
  - B: −4096..4094, and imm[0] must be 0.
  - J: −1048576..1048574, and imm[0] must be 0.
  - U: imm[11:0] must be 0.
  - R: imm is ignored.
- Error precedence: fmt=7 gives 3; an alignment violation gives 2; a range violation gives 1.
- Error handling:
  - An accepted erroneous request is consumed (handshake completes) but not enqueued, and the counter does not advance.
  - err is set and err_code is updated.
  - If an error and clr_err occur in the same cycle, the set wins.
- Field layout:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - I_SHIFT: {funct7, imm[4:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
- Address counter:
  - On a legal enqueue, the entry is tagged with the current counter value and the counter advances by 4, wrapping modulo 2^ADDR_W.
  - addr_load has priority over the increment. If both occur in the same cycle, the entry takes addr_in and the counter becomes addr_in+4.
- FIFO:
  - Pop on out_valid && out_ready. Simultaneous push and pop with count in 1..DEPTH−1 leaves count unchanged.
  - out_inst and out_addr come from the head entry and hold stable while out_valid && !out_ready.
  - When empty, out_valid=0 and out_inst/out_addr show the last popped value (0 after reset).
  - Read and write pointers wrap at DEPTH.

Decomposition:
- Shared package `riscv_enc_pkg`: enum for fmt codes, enum for err codes, and localparams for the immediate limits (IMM12_MIN/MAX, B_MIN/MAX, J_MIN/MAX).
- One sub-module `enc_fifo`: a parameterized DEPTH×(32+ADDR_W) synchronous FIFO with count, full and empty outputs and the same rst_n.
- Encoder and range checker stay combinational logic inside inst_encoder.

Test Plan:
- ADDI x1,x0,−1 (fmt=1, opcode=0x13, rd=1, rs1=0, funct3=0, imm=−1), out_ready=1 → next cycle out_valid=1, out_inst=0xFFF00093, out_addr=0x0; second request gets out_addr=0x4.
- SRAI x5,x5,3 (fmt=2, funct7=0x20, funct3=5, imm=3) → 0x4032D293. JAL x1,+8 (fmt=6, opcode=0x6F, imm=8) → 0x008000EF.
- BEQ x1,x2,−4 (fmt=4, opcode=0x63, imm=−4) → 0xFE208EE3. BEQ with imm=−3 → not enqueued, err=1, err_code=2, counter unchanged.
- ADDI with imm=2048 → err_code=1. fmt=7 → err_code=3. clr_err asserted alone clears err; clr_err asserted with a new error leaves err=1.
- out_ready=0, push 4 legal requests → in_ready=0 after the 4th, with a 5th held off. out_ready=1 → entries drain in order with addresses 0,4,8,C. Pop and push in the same cycle while full → the push is refused.
- addr_load with addr_in=0xFFFFFFFC, then 2 pushes → out_addr=0xFFFFFFFC then 0x0. Assert rst_n=0 with 3 entries queued → out_valid=0 and counter=BASE_ADDR next cycle.
